// File: rtl/catcore_pkg.sv
// Types and constants shared by the CatCORE fetch path and control unit.
package catcore_pkg;

  typedef enum logic [1:0] {
    ST_CARGA  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_PARADO = 2'd2
  } estado_t;

  // The opcode occupies the OPCODE_LARGURA most significant bits of every word.
  localparam int OPCODE_LARGURA = 6;
  localparam int OPCODE_DESLOC_MSB = 0;

  localparam logic [OPCODE_LARGURA-1:0] OPCODE_HALT = 6'b111110;
  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/ram_sincrona.sv
// Single write port, single synchronous read port; the array is never reset.
module ram_sincrona #(
  parameter int LARGURA = 32,
  parameter int PROFUNDIDADE = 231,
  localparam int AW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1
) (
  input  logic               clock,
  input  logic               escrita_en,
  input  logic [AW-1:0]      escrita_end,
  input  logic [LARGURA-1:0] escrita_dado,
  input  logic               leitura_en,
  input  logic [AW-1:0]      leitura_end,
  output logic [LARGURA-1:0] leitura_dado
);

  logic [LARGURA-1:0] mem_q [PROFUNDIDADE];
  logic [LARGURA-1:0] leitura_q;

  // Read data only moves on an enabled read, so it holds between fetches.
  always_ff @(posedge clock) begin
    if (escrita_en) mem_q[escrita_end] <= escrita_dado;
    if (leitura_en) leitura_q <= mem_q[leitura_end];
  end

  assign leitura_dado = leitura_q;

endmodule

// File: rtl/memoria_instrucao_carregavel.sv
// Run-time loadable instruction memory: load port, 1-cycle fetch port,
// range checking and HALT detection.
module memoria_instrucao_carregavel #(
  parameter int LARGURA = 32,
  parameter int LARGURA_END = 32,
  parameter int PROFUNDIDADE = 231,
  parameter logic [catcore_pkg::OPCODE_LARGURA-1:0] OPCODE_HALT = catcore_pkg::OPCODE_HALT
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              carga_inicio,
  input  logic                              carga_fim,
  input  logic                              carga_valido,
  input  logic [LARGURA_END-1:0]            carga_endereco,
  input  logic [LARGURA-1:0]                carga_dado,
  input  logic                              busca_valido,
  input  logic [LARGURA_END-1:0]            busca_endereco,
  output logic [LARGURA-1:0]                instrucao,
  output logic [LARGURA_END-1:0]            endereco,
  output logic                              instrucao_valida,
  output logic                              erro_endereco,
  output logic                              parado,
  output logic                              em_carga,
  output logic [$clog2(PROFUNDIDADE+1)-1:0] palavras_carregadas
);
  import catcore_pkg::*;

  localparam int AW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam int CW = $clog2(PROFUNDIDADE+1);
  localparam int OP_MSB = LARGURA - 1 - OPCODE_DESLOC_MSB;

  estado_t                estado_q, estado_d;
  logic                   sel_ram_q, sel_ram_d;
  logic                   valida_q, valida_d;
  logic                   erro_q, erro_d;
  logic [LARGURA_END-1:0] end_q, end_d;
  logic [CW-1:0]          cont_q, cont_d;

  logic                   escrita_en, leitura_en;
  logic [LARGURA-1:0]     ram_dado;
  logic                   carga_em_faixa, busca_em_faixa;
  logic                   halt_visto;

  assign carga_em_faixa = carga_endereco < LARGURA_END'(PROFUNDIDADE);
  assign busca_em_faixa = busca_endereco < LARGURA_END'(PROFUNDIDADE);

  ram_sincrona #(
    .LARGURA      (LARGURA),
    .PROFUNDIDADE (PROFUNDIDADE)
  ) u_ram (
    .clock        (clock),
    .escrita_en   (escrita_en),
    .escrita_end  (carga_endereco[AW-1:0]),
    .escrita_dado (carga_dado),
    .leitura_en   (leitura_en),
    .leitura_end  (busca_endereco[AW-1:0]),
    .leitura_dado (ram_dado)
  );

  // HALT is decoded straight off the RAM output so parado rises with its valid pulse.
  assign halt_visto = valida_q && sel_ram_q && (estado_q == ST_EXEC) &&
                      (ram_dado[OP_MSB -: OPCODE_LARGURA] == OPCODE_HALT);

  always_comb begin
    estado_d   = estado_q;
    sel_ram_d  = sel_ram_q;
    valida_d   = 1'b0;
    erro_d     = 1'b0;
    end_d      = end_q;
    cont_d     = cont_q;
    escrita_en = 1'b0;
    leitura_en = 1'b0;
    case (estado_q)
      ST_CARGA: begin
        if (carga_valido) begin
          if (carga_em_faixa) begin
            escrita_en = 1'b1;
            if (cont_q != CW'(PROFUNDIDADE)) cont_d = cont_q + CW'(1);
          end else begin
            erro_d = 1'b1;
          end
        end
        if (carga_fim) estado_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (carga_inicio) begin
          estado_d = ST_CARGA;
          cont_d   = '0;
        end else if (halt_visto) begin
          estado_d = ST_PARADO;
        end else if (busca_valido) begin
          valida_d = 1'b1;
          end_d    = busca_endereco + LARGURA_END'(1);
          if (busca_em_faixa) begin
            leitura_en = 1'b1;
            sel_ram_d  = 1'b1;
          end else begin
            sel_ram_d  = 1'b0;
            erro_d     = 1'b1;
          end
        end
      end
      ST_PARADO: begin
        if (carga_inicio) begin
          estado_d = ST_CARGA;
          cont_d   = '0;
        end
      end
      default: begin
        estado_d = ST_CARGA;
        cont_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= ST_CARGA;
      sel_ram_q <= 1'b0;
      valida_q  <= 1'b0;
      erro_q    <= 1'b0;
      end_q     <= '0;
      cont_q    <= '0;
    end else begin
      estado_q  <= estado_d;
      sel_ram_q <= sel_ram_d;
      valida_q  <= valida_d;
      erro_q    <= erro_d;
      end_q     <= end_d;
      cont_q    <= cont_d;
    end
  end

  // Out-of-range fetches and the post-reset state both present NOP.
  assign instrucao           = sel_ram_q ? ram_dado : LARGURA'(NOP);
  assign endereco            = end_q;
  assign instrucao_valida    = valida_q;
  assign erro_endereco       = erro_q;
  assign parado              = (estado_q == ST_PARADO) || halt_visto;
  assign em_carga            = (estado_q == ST_CARGA);
  assign palavras_carregadas = cont_q;

endmodule

// File: tb/tb_memoria_instrucao_carregavel.sv
// Directed bench for memoria_instrucao_carregavel with default parameters.
module tb_memoria_instrucao_carregavel;

  logic        clock;
  logic        reset;
  logic        carga_inicio, carga_fim, carga_valido;
  logic [31:0] carga_endereco, carga_dado;
  logic        busca_valido;
  logic [31:0] busca_endereco;
  logic [31:0] instrucao, endereco;
  logic        instrucao_valida, erro_endereco, parado, em_carga;
  logic [7:0]  palavras_carregadas;

  int compared = 0;
  int mismatched = 0;

  memoria_instrucao_carregavel dut (
    .clock               (clock),
    .reset               (reset),
    .carga_inicio        (carga_inicio),
    .carga_fim           (carga_fim),
    .carga_valido        (carga_valido),
    .carga_endereco      (carga_endereco),
    .carga_dado          (carga_dado),
    .busca_valido        (busca_valido),
    .busca_endereco      (busca_endereco),
    .instrucao           (instrucao),
    .endereco            (endereco),
    .instrucao_valida    (instrucao_valida),
    .erro_endereco       (erro_endereco),
    .parado              (parado),
    .em_carga            (em_carga),
    .palavras_carregadas (palavras_carregadas)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic carregar(input logic [31:0] a, input logic [31:0] d);
    carga_valido = 1'b1; carga_endereco = a; carga_dado = d;
    tick();
    carga_valido = 1'b0;
  endtask

  task automatic pulso_fim();
    carga_fim = 1'b1; tick(); carga_fim = 1'b0;
  endtask

  task automatic pulso_inicio();
    carga_inicio = 1'b1; tick(); carga_inicio = 1'b0;
  endtask

  task automatic buscar(input logic [31:0] a);
    busca_valido = 1'b1; busca_endereco = a;
    tick();
    busca_valido = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    compared++; if (instrucao !== 32'h0) begin mismatched++; $display("FAIL reset_instrucao: got %h expected %h", instrucao, 32'h0); end
    compared++; if (endereco !== 32'h0) begin mismatched++; $display("FAIL reset_endereco: got %h expected %h", endereco, 32'h0); end
    compared++; if (instrucao_valida !== 1'b0) begin mismatched++; $display("FAIL reset_valida: got %b expected 0", instrucao_valida); end
    compared++; if (erro_endereco !== 1'b0) begin mismatched++; $display("FAIL reset_erro: got %b expected 0", erro_endereco); end
    compared++; if (parado !== 1'b0) begin mismatched++; $display("FAIL reset_parado: got %b expected 0", parado); end
    compared++; if (em_carga !== 1'b1) begin mismatched++; $display("FAIL reset_em_carga: got %b expected 1", em_carga); end
    compared++; if (palavras_carregadas !== 8'd0) begin mismatched++; $display("FAIL reset_palavras: got %0d expected 0", palavras_carregadas); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_carga_busca();
    carregar(32'd1, 32'hFC00_0021);
    carregar(32'd2, 32'hF800_0000);
    compared++; if (palavras_carregadas !== 8'd2) begin mismatched++; $display("FAIL carga_palavras: got %0d expected 2", palavras_carregadas); end
    pulso_fim();
    compared++; if (em_carga !== 1'b0) begin mismatched++; $display("FAIL exec_em_carga: got %b expected 0", em_carga); end
    buscar(32'd1);
    compared++; if (instrucao !== 32'hFC00_0021) begin mismatched++; $display("FAIL busca1_instrucao: got %h expected %h", instrucao, 32'hFC00_0021); end
    compared++; if (endereco !== 32'd2) begin mismatched++; $display("FAIL busca1_endereco: got %h expected %h", endereco, 32'd2); end
    compared++; if (instrucao_valida !== 1'b1) begin mismatched++; $display("FAIL busca1_valida: got %b expected 1", instrucao_valida); end
    compared++; if (palavras_carregadas !== 8'd2) begin mismatched++; $display("FAIL busca1_palavras: got %0d expected 2", palavras_carregadas); end
    compared++; if (parado !== 1'b0) begin mismatched++; $display("FAIL busca1_parado: got %b expected 0", parado); end
    tick();
    compared++; if (instrucao_valida !== 1'b0) begin mismatched++; $display("FAIL busca1_pulso: got %b expected 0", instrucao_valida); end
    compared++; if (instrucao !== 32'hFC00_0021) begin mismatched++; $display("FAIL busca1_retencao: got %h expected %h", instrucao, 32'hFC00_0021); end
  endtask

  task automatic test_halt();
    buscar(32'd2);
    compared++; if (instrucao !== 32'hF800_0000) begin mismatched++; $display("FAIL halt_instrucao: got %h expected %h", instrucao, 32'hF800_0000); end
    compared++; if (parado !== 1'b1) begin mismatched++; $display("FAIL halt_parado: got %b expected 1", parado); end
    compared++; if (instrucao_valida !== 1'b1) begin mismatched++; $display("FAIL halt_valida: got %b expected 1", instrucao_valida); end
    buscar(32'd1);
    compared++; if (instrucao_valida !== 1'b0) begin mismatched++; $display("FAIL halt_ignora_busca: got %b expected 0", instrucao_valida); end
    compared++; if (parado !== 1'b1) begin mismatched++; $display("FAIL halt_nivel: got %b expected 1", parado); end
    compared++; if (instrucao !== 32'hF800_0000) begin mismatched++; $display("FAIL halt_retencao: got %h expected %h", instrucao, 32'hF800_0000); end
    tick();
    compared++; if (instrucao_valida !== 1'b0) begin mismatched++; $display("FAIL halt_sem_pulso: got %b expected 0", instrucao_valida); end
  endtask

  task automatic test_fora_faixa();
    pulso_inicio();
    compared++; if (em_carga !== 1'b1) begin mismatched++; $display("FAIL reinicio_em_carga: got %b expected 1", em_carga); end
    compared++; if (parado !== 1'b0) begin mismatched++; $display("FAIL reinicio_parado: got %b expected 0", parado); end
    compared++; if (palavras_carregadas !== 8'd0) begin mismatched++; $display("FAIL reinicio_palavras: got %0d expected 0", palavras_carregadas); end
    pulso_fim();
    buscar(32'd231);
    compared++; if (instrucao !== 32'h0) begin mismatched++; $display("FAIL faixa_instrucao: got %h expected %h", instrucao, 32'h0); end
    compared++; if (instrucao_valida !== 1'b1) begin mismatched++; $display("FAIL faixa_valida: got %b expected 1", instrucao_valida); end
    compared++; if (erro_endereco !== 1'b1) begin mismatched++; $display("FAIL faixa_erro: got %b expected 1", erro_endereco); end
    compared++; if (endereco !== 32'd232) begin mismatched++; $display("FAIL faixa_endereco: got %h expected %h", endereco, 32'd232); end
    tick();
    compared++; if (erro_endereco !== 1'b0) begin mismatched++; $display("FAIL faixa_erro_pulso: got %b expected 0", erro_endereco); end
    compared++; if (instrucao_valida !== 1'b0) begin mismatched++; $display("FAIL faixa_valida_pulso: got %b expected 0", instrucao_valida); end
    buscar(32'd230);
    compared++; if (erro_endereco !== 1'b0) begin mismatched++; $display("FAIL faixa_limite_erro: got %b expected 0", erro_endereco); end
    buscar(32'hFFFF_FFFF);
    compared++; if (endereco !== 32'h0) begin mismatched++; $display("FAIL wrap_endereco: got %h expected %h", endereco, 32'h0); end
    compared++; if (erro_endereco !== 1'b1) begin mismatched++; $display("FAIL wrap_erro: got %b expected 1", erro_endereco); end
  endtask

  task automatic test_erro_carga();
    pulso_inicio();
    carregar(32'd44, 32'hA5A5_0044);
    compared++; if (palavras_carregadas !== 8'd1) begin mismatched++; $display("FAIL carga44_palavras: got %0d expected 1", palavras_carregadas); end
    carregar(32'd300, 32'hDEAD_BEEF);
    compared++; if (erro_endereco !== 1'b1) begin mismatched++; $display("FAIL carga300_erro: got %b expected 1", erro_endereco); end
    compared++; if (palavras_carregadas !== 8'd1) begin mismatched++; $display("FAIL carga300_palavras: got %0d expected 1", palavras_carregadas); end
    tick();
    compared++; if (erro_endereco !== 1'b0) begin mismatched++; $display("FAIL carga300_pulso: got %b expected 0", erro_endereco); end
    // Fetches in load state are ignored.
    buscar(32'd44);
    compared++; if (instrucao_valida !== 1'b0) begin mismatched++; $display("FAIL carga_ignora_busca: got %b expected 0", instrucao_valida); end
    pulso_fim();
    buscar(32'd44);
    compared++; if (instrucao !== 32'hA5A5_0044) begin mismatched++; $display("FAIL leitura44: got %h expected %h", instrucao, 32'hA5A5_0044); end
  endtask

  task automatic test_inicio_com_busca();
    carga_inicio = 1'b1; busca_valido = 1'b1; busca_endereco = 32'd1;
    tick();
    carga_inicio = 1'b0; busca_valido = 1'b0;
    compared++; if (instrucao_valida !== 1'b0) begin mismatched++; $display("FAIL inicio_busca_valida: got %b expected 0", instrucao_valida); end
    compared++; if (em_carga !== 1'b1) begin mismatched++; $display("FAIL inicio_busca_em_carga: got %b expected 1", em_carga); end
    compared++; if (palavras_carregadas !== 8'd0) begin mismatched++; $display("FAIL inicio_busca_palavras: got %0d expected 0", palavras_carregadas); end
    compared++; if (instrucao !== 32'hA5A5_0044) begin mismatched++; $display("FAIL inicio_busca_retencao: got %h expected %h", instrucao, 32'hA5A5_0044); end
    tick();
    compared++; if (instrucao_valida !== 1'b0) begin mismatched++; $display("FAIL inicio_busca_tardia: got %b expected 0", instrucao_valida); end
  endtask

  task automatic test_back_to_back_reset();
    for (int i = 0; i < 5; i++) carregar(i, 32'h1000_0000 + i);
    compared++; if (palavras_carregadas !== 8'd5) begin mismatched++; $display("FAIL b2b_palavras: got %0d expected 5", palavras_carregadas); end
    carga_fim = 1'b1; carga_valido = 1'b1; carga_endereco = 32'd5; carga_dado = 32'h1000_0005;
    tick();
    carga_fim = 1'b0; carga_valido = 1'b0;
    compared++; if (palavras_carregadas !== 8'd6) begin mismatched++; $display("FAIL fim_com_carga_palavras: got %0d expected 6", palavras_carregadas); end
    busca_valido = 1'b1; busca_endereco = 32'd5;
    tick();
    compared++; if (instrucao !== 32'h1000_0005) begin mismatched++; $display("FAIL fim_com_carga_leitura: got %h expected %h", instrucao, 32'h1000_0005); end
    busca_endereco = 32'd0;
    tick();
    compared++; if (instrucao !== 32'h1000_0000) begin mismatched++; $display("FAIL b2b0_instrucao: got %h expected %h", instrucao, 32'h1000_0000); end
    compared++; if (endereco !== 32'd1) begin mismatched++; $display("FAIL b2b0_endereco: got %h expected %h", endereco, 32'd1); end
    busca_endereco = 32'd1;
    tick();
    compared++; if (instrucao !== 32'h1000_0001) begin mismatched++; $display("FAIL b2b1_instrucao: got %h expected %h", instrucao, 32'h1000_0001); end
    compared++; if (instrucao_valida !== 1'b1) begin mismatched++; $display("FAIL b2b1_valida: got %b expected 1", instrucao_valida); end
    busca_endereco = 32'd2;
    #2 reset = 1'b1;
    #1;
    compared++; if (instrucao !== 32'h0) begin mismatched++; $display("FAIL rst_meio_instrucao: got %h expected %h", instrucao, 32'h0); end
    compared++; if (endereco !== 32'h0) begin mismatched++; $display("FAIL rst_meio_endereco: got %h expected %h", endereco, 32'h0); end
    compared++; if (instrucao_valida !== 1'b0) begin mismatched++; $display("FAIL rst_meio_valida: got %b expected 0", instrucao_valida); end
    compared++; if (em_carga !== 1'b1) begin mismatched++; $display("FAIL rst_meio_em_carga: got %b expected 1", em_carga); end
    compared++; if (palavras_carregadas !== 8'd0) begin mismatched++; $display("FAIL rst_meio_palavras: got %0d expected 0", palavras_carregadas); end
    busca_valido = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    pulso_fim();
    buscar(32'd3);
    compared++; if (instrucao !== 32'h1000_0003) begin mismatched++; $display("FAIL pos_reset_leitura3: got %h expected %h", instrucao, 32'h1000_0003); end
    compared++; if (endereco !== 32'd4) begin mismatched++; $display("FAIL pos_reset_endereco: got %h expected %h", endereco, 32'd4); end
  endtask

  task automatic test_saturacao();
    pulso_inicio();
    for (int i = 0; i < 231; i++) carregar(i, 32'h2000_0000 + i);
    compared++; if (palavras_carregadas !== 8'd231) begin mismatched++; $display("FAIL sat_palavras: got %0d expected 231", palavras_carregadas); end
    compared++; if (erro_endereco !== 1'b0) begin mismatched++; $display("FAIL sat_limite_erro: got %b expected 0", erro_endereco); end
    carregar(32'd7, 32'h3000_0007);
    compared++; if (palavras_carregadas !== 8'd231) begin mismatched++; $display("FAIL sat_mantem: got %0d expected 231", palavras_carregadas); end
    pulso_fim();
    buscar(32'd230);
    compared++; if (instrucao !== 32'h2000_00E6) begin mismatched++; $display("FAIL sat_leitura230: got %h expected %h", instrucao, 32'h2000_00E6); end
    buscar(32'd7);
    compared++; if (instrucao !== 32'h3000_0007) begin mismatched++; $display("FAIL sat_leitura7: got %h expected %h", instrucao, 32'h3000_0007); end
  endtask

  initial begin
    reset = 1'b1;
    carga_inicio = 1'b0; carga_fim = 1'b0; carga_valido = 1'b0;
    carga_endereco = '0; carga_dado = '0;
    busca_valido = 1'b0; busca_endereco = '0;
    test_reset();
    test_carga_busca();
    test_halt();
    test_fora_faixa();
    test_erro_carga();
    test_inicio_com_busca();
    test_back_to_back_reset();
    test_saturacao();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/memoria_instrucao_carregavel.md
# memoria_instrucao_carregavel

Parametrised, run-time loadable instruction memory for the CatCORE processor, replacing the fixed-content instruction ROM. It has a load port for a bootloader or debug host, a single-cycle-latency fetch port with next-address output, range checking, and HALT-opcode detection. It sits between the PC/fetch stage and the control unit and runs on the single core clock.

## Interface
Parameters:
- LARGURA, 32, instruction word width in bits
- LARGURA_END, 32, address width for fetch and load ports
- PROFUNDIDADE, 231, number of instruction words; valid addresses are 0..PROFUNDIDADE-1
- OPCODE_HALT, 6'b111110, value of bits [LARGURA-1:LARGURA-6] that stops execution

Ports:
- clock  in  1  core clock, all activity on rising edge
- reset  in  1  asynchronous, active-high
- carga_inicio  in  1  single-cycle pulse that enters load mode
- carga_fim  in  1  single-cycle pulse that leaves load mode and enters execution
- carga_valido  in  1  load write strobe
- carga_endereco  in  LARGURA_END  load write address
- carga_dado  in  LARGURA  load write data
- busca_valido  in  1  fetch request
- busca_endereco  in  LARGURA_END  fetch address (the PC value)
- instrucao  out  LARGURA  fetched instruction
- endereco  out  LARGURA_END  busca_endereco+1, truncated to LARGURA_END
- instrucao_valida  out  1  one-cycle pulse that qualifies instrucao and endereco
- erro_endereco  out  1  one-cycle pulse for an out-of-range fetch or load
- parado  out  1  HALT fetched; level signal
- em_carga  out  1  high while in load state
- palavras_carregadas  out  $clog2(PROFUNDIDADE+1)  count of accepted load writes

## Operation
- States: ST_CARGA, ST_EXEC, ST_PARADO. Reset enters ST_CARGA.
- ST_CARGA:
  - carga_valido with an address below PROFUNDIDADE writes the word and increments palavras_carregadas. The counter saturates at PROFUNDIDADE.
  - A write to an address at or above PROFUNDIDADE is dropped and pulses erro_endereco.
  - carga_fim moves to ST_EXEC. If carga_valido is high in the same cycle, the write completes first.
  - busca_valido is ignored.
- ST_EXEC:
  - A fetch is accepted when busca_valido is high. For an in-range address, instrucao takes the stored word.
  - For an out-of-range address, instrucao becomes all zeros (NOP) and erro_endereco pulses. instrucao_valida still pulses.
  - A fetched word whose opcode field equals OPCODE_HALT moves the block to ST_PARADO and sets parado.
  - carga_inicio moves to ST_CARGA. If busca_valido is high in the same cycle, the fetch is dropped and no instrucao_valida pulse follows.
- ST_PARADO:
  - Fetches are ignored.
  - carga_inicio moves to ST_CARGA and clears parado.
- Entering ST_CARGA by any path (including reset) clears palavras_carregadas to 0.
- Memory array contents are not reset and are retained across reset. Words never loaded read as undefined.
- em_carga = (state == ST_CARGA).

## Timing
- Reset values: state ST_CARGA, instrucao 0, endereco 0, instrucao_valida 0, erro_endereco 0, parado 0, em_carga 1, palavras_carregadas 0.
- Fetch latency is one cycle: a request sampled at edge N produces instrucao, endereco and instrucao_valida after edge N.
- instrucao and endereco hold their values until the next accepted fetch.
- Back-to-back fetches are accepted every cycle.
- parado rises in the same cycle as the instrucao_valida of the HALT word.
- A load write at edge N is readable by a fetch sampled at edge N+1 or later, which requires carga_fim to have been issued.
- erro_endereco is registered and asserts one cycle after the offending request.
- endereco wraps modulo 2^LARGURA_END; the all-ones address yields 0.
- A reset asserted mid-fetch or mid-load clears outputs immediately. A write in flight at that edge is not guaranteed.

## Structure
- Package catcore_pkg holds:
  - the state enum
  - OPCODE_HALT and the NOP constant
  - the opcode field position constants, shared with the control unit
- Sub-module ram_sincrona: one write port and one synchronous read port, parameterised by LARGURA and PROFUNDIDADE, with no reset on the array.
- The FSM, range checks, counter and output registers sit in the top level.

## Test plan
- Reset, load 0xFC000021 at address 1 and 0xF8000000 at address 2, pulse carga_fim, fetch address 1 → next cycle instrucao=0xFC000021, endereco=2, instrucao_valida=1, palavras_carregadas=2.
- Fetch address 2 (HALT) → instrucao=0xF8000000 and parado=1 in the same cycle. A subsequent fetch of address 1 produces no instrucao_valida.
- In ST_EXEC, fetch address 231 → instrucao=0, instrucao_valida=1, erro_endereco=1 for exactly one cycle.
- In ST_CARGA, write address 300 → erro_endereco pulse, palavras_carregadas unchanged, and a later read of address 44 (300 mod 256) still returns its old value.
- In ST_EXEC, assert carga_inicio and busca_valido in the same cycle → no instrucao_valida, em_carga=1, palavras_carregadas=0.
- Load addresses 0–4, fetch continuously, assert reset mid-stream → all outputs reset immediately. After carga_fim, fetching address 3 returns the pre-reset word.
